// File: rtl/apb_mem_slave.sv
// APB completer that turns APB transfers into handshaked single-word memory requests.
// Define APB_SLV_RDONLY_REGION_EN to make the top RO_BYTES of the window reject writes.

module apb_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1100_0000,
  parameter int                    MEM_BYTES  = 1024,
  parameter int                    TIMEOUT    = 16
`ifdef APB_SLV_RDONLY_REGION_EN
  , parameter int                  RO_BYTES   = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [1:0]              dsel,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ack
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic [1:0]            r_dsel;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_offsetAligned;
  logic                  w_inRange;
  logic                  w_sizeErr;
  logic                  w_roErr;
  logic                  w_err;
  logic [1:0]            w_lane;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rshift;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_timeout;

  // The offset wraps for addresses below the base, so the lower bound is checked separately.
  assign w_offset        = r_addr - BASE_ADDR;
  assign w_offsetAligned = {w_offset[ADDR_WIDTH-1:2], 2'b00};
  assign w_inRange       = (r_addr >= BASE_ADDR) && (w_offset < ADDR_WIDTH'(MEM_BYTES));
  assign w_sizeErr       = (r_dsel == 2'd3) || ((r_dsel == SZ_HALF) && r_addr[0]);

`ifdef APB_SLV_RDONLY_REGION_EN
  assign w_roErr = r_write && (w_offset >= ADDR_WIDTH'(MEM_BYTES - RO_BYTES));
`else
  assign w_roErr = 1'b0;
`endif

  assign w_err     = !w_inRange || w_sizeErr || w_roErr;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_lane = 2'd0;
    w_be   = '1;
    case (r_dsel)
      SZ_HALF: begin
        w_lane = {r_addr[1], 1'b0};
        w_be   = r_addr[1] ? BE_WIDTH'(4'b1100) : BE_WIDTH'(4'b0011);
      end
      SZ_BYTE: begin
        w_lane = r_addr[1:0];
        w_be   = BE_WIDTH'(4'b0001) << r_addr[1:0];
      end
      default: begin
        w_lane = 2'd0;
        w_be   = '1;
      end
    endcase
  end

  assign w_wdata  = r_wdata << {w_lane, 3'b000};
  assign w_rshift = mem_data_out >> {w_lane, 3'b000};

  always_comb begin
    w_rdata = w_rshift;
    case (r_dsel)
      SZ_HALF: w_rdata = DATA_WIDTH'(w_rshift[15:0]);
      SZ_BYTE: w_rdata = DATA_WIDTH'(w_rshift[7:0]);
      default: w_rdata = w_rshift;
    endcase
  end

  // Abort (psel dropped) takes precedence over ack; ack takes precedence over timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_dsel      <= '0;
      prdata      <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_be      <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (psel && !penable) begin
            r_addr  <= paddr;
            r_wdata <= pwdata;
            r_write <= pwrite;
            r_dsel  <= dsel;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (w_err) begin
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
            r_state <= S_RESP;
          end else begin
            mem_wr      <= r_write;
            mem_rd      <= !r_write;
            mem_be      <= w_be;
            mem_address <= w_offsetAligned;
            mem_data_in <= w_wdata;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!psel || mem_ack || w_timeout) begin
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_be      <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
          end
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (mem_ack) begin
            pready  <= 1'b1;
            pslverr <= 1'b0;
            prdata  <= r_write ? '0 : w_rdata;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
APB completer that accepts APB transfers from the bridge's peripheral-side master and converts them into handshaked single-word memory requests with byte enables. It decodes the address window and sizes the access from dsel (FULLWORD/HALFWORD/BYTE). It returns PREADY/PSLVERR/PRDATA to the master. Memory latency is variable; a built-in timeout converts a non-responding memory into an error response.

Parameters:
ADDR_WIDTH, 32, APB/memory address width
DATA_WIDTH, 32, APB/memory data width; fixed at 32 (4 byte lanes)
BASE_ADDR, 32'h1100_0000, first byte address of the decoded window
MEM_BYTES, 1024, window size in bytes; power of two
TIMEOUT, 16, max cycles to wait for mem_ack; range 2..255

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data, right-justified
dsel  in  2  access size: 0=FULLWORD, 1=HALFWORD, 2=BYTE, 3=reserved
prdata  out  DATA_WIDTH  read data, right-justified, zero-extended
pready  out  1  transfer completes in this cycle
pslverr  out  1  error response; valid only while pready=1
mem_wr  out  1  memory write strobe, held until ack
mem_rd  out  1  memory read strobe, held until ack
mem_be  out  DATA_WIDTH/8  byte-lane enables
mem_address  out  ADDR_WIDTH  word-aligned offset into window (paddr-BASE_ADDR, [1:0]=0)
mem_data_in  out  DATA_WIDTH  lane-positioned write data
mem_data_out  in  DATA_WIDTH  read data from memory, valid with mem_ack
mem_ack  in  1  memory completion, single-cycle pulse

Behaviour:
- Clock and reset: single clock clk; rst is synchronous active-high. On reset, all outputs are 0 and the FSM is in IDLE. Reset wins over any in-flight transfer: strobes drop on the next edge and no response is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: when psel=1 and penable=0 (setup phase) is sampled, capture paddr, pwrite, pwdata and dsel, then go to ACCESS. psel=1 with penable=1 in IDLE is ignored.
- ACCESS: decode the captured request.
  - Error if any of: address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES-1]; dsel=3; HALFWORD with paddr[0]=1.
  - On error: go to RESP with pslverr=1. No memory strobe is issued.
  - Otherwise: assert mem_wr or mem_rd, drive mem_be, mem_address and mem_data_in, clear the timeout counter, and go to WAIT.
- Lane rules, by paddr[1:0]:
  - FULLWORD: be=4'b1111; low address bits are ignored.
  - HALFWORD: be=4'b0011 when paddr[1]=0, 4'b1100 when paddr[1]=1.
  - BYTE: be=4'b0001 << paddr[1:0].
  - Write data is pwdata shifted left by 8*lane, so pwdata[7:0] lands on the lowest enabled lane.
  - Read data is mem_data_out shifted right by the same amount and masked to the access size.
- WAIT: strobe and control signals stay stable. The counter increments each cycle.
  - mem_ack sampled: drop the strobe, latch the lane-extracted read data into prdata (reads only), go to RESP with pslverr=0.
  - Counter reaches TIMEOUT-1 with no ack: drop the strobe, go to RESP with pslverr=1 and prdata=0.
  - Ack and timeout in the same cycle: ack wins.
- RESP: pready=1 for exactly one cycle, then go to IDLE. prdata and pslverr are cleared to 0 in every state except RESP.
- Latency, counting edges from the setup-phase edge E0:
  - Error response: pready high in the cycle after E1, transfer completes at E2.
  - Memory acking in the cycle its strobe is first high: completes at E3.
  - Each additional ack-delay cycle adds one cycle.
- Back-to-back transfers: a setup phase in the cycle immediately after completion is accepted. There is no dead cycle.
- Protocol violation (psel=0 while in ACCESS or WAIT): abort to IDLE, drop the strobe, issue no pready. A late mem_ack after the abort is ignored.
- A mem_ack outside WAIT is ignored.

Optional Feature:
Macro APB_SLV_RDONLY_REGION_EN.
- When defined: adds parameter RO_BYTES (default 64). The top RO_BYTES of the window are read-only. A write there gives pslverr=1 in RESP with no mem_wr issued. Reads there behave normally.
- When undefined: the parameter and the check are absent, and the whole window is writable.

Test Plan:
- FULLWORD write 0x1100_00F0 data 0x000A_3210, ack 0 cycles late -> mem_wr=1, mem_be=4'hF, mem_address=0x0F0, mem_data_in=0x000A_3210; completes at E3 with pslverr=0. FULLWORD read of the same address -> prdata=0x000A_3210.
- HALFWORD write 0x1100_0012 data 0x510F_CB29 -> be=4'b1100, mem_data_in=0xCB29_0000. Read back with mem_data_out=0xCB29_0000 -> prdata=0x0000_CB29.
- BYTE write 0x1100_003D data 0x34 -> be=4'b0010, mem_data_in[15:8]=0x34. Also HALFWORD at 0x1100_0013 -> error response with no strobe.
- Address 0x1100_0400 (outside a 1024-byte window) and dsel=3 -> pready+pslverr=1 at E2, mem_wr and mem_rd never asserted.
- Read at 0x1100_0000 with mem_ack withheld, TIMEOUT=16 -> mem_rd high 16 cycles then dropped, pslverr=1, prdata=0. Ack on the final cycle -> pslverr=0.
- Assert rst while in WAIT -> outputs 0 on the next edge; a later mem_ack produces no pready. Eight back-to-back writes complete with no idle cycle between transfers.
